// File: rtl/tpu_job_seq.sv
// tpu_job_seq: runs one GEMM job per command against the tpuv1 memory-mapped port.
// The job optionally clears C, loads DIM A rows and DIM B rows from the input stream,
// pulses the start address, waits out the array, then streams the 2*DIM C half-rows out.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   cmd_valid/cmd_ready/cmd_accum    job request; accum=1 keeps C, accum=0 zeroes C first
//   in_valid/in_ready/in_data        A rows then B rows, DIM signed bytes per beat
//   out_valid/out_ready/out_data     C half-rows, four 16-bit elements per beat
//   busy, done                       busy whenever not idle; done pulses for one cycle at job end
//   tpu_r_w/tpu_addr/tpu_dataIn      registered TPU bus (r_w=1 write)
//   tpu_dataOut                      TPU read data, combinational from tpu_addr
module tpu_job_seq #(
    parameter int unsigned DIM      = 8,
    parameter int unsigned ADDRW    = 16,
    parameter int unsigned DATAW    = 64,
    parameter int unsigned WAIT_CYC = 3 * DIM
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_accum,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data,
    output logic             busy,
    output logic             done,
    output logic             tpu_r_w,
    output logic [ADDRW-1:0] tpu_addr,
    output logic [DATAW-1:0] tpu_dataIn,
    input  logic [DATAW-1:0] tpu_dataOut
);

    localparam int unsigned CW = $clog2(2 * DIM) + 1;
    localparam int unsigned WW = $clog2(WAIT_CYC) + 1;

    localparam logic [CW-1:0]    LAST_ROW   = CW'(DIM - 1);
    localparam logic [CW-1:0]    LAST_HALF  = CW'(2 * DIM - 1);
    localparam logic [WW-1:0]    LAST_WAIT  = WW'(WAIT_CYC);
    localparam logic [ADDRW-1:0] A_BASE     = ADDRW'(32'h100);
    localparam logic [ADDRW-1:0] B_BASE     = ADDRW'(32'h200);
    localparam logic [ADDRW-1:0] C_BASE     = ADDRW'(32'h300);
    localparam logic [ADDRW-1:0] START_ADDR = ADDRW'(32'h400);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR_C, S_LOAD_A, S_LOAD_B, S_START, S_WAIT, S_READ_C, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;

    logic             r_w_d, cmd_ready_d, in_ready_d, out_valid_d, busy_d, done_d;
    logic [ADDRW-1:0] addr_d;
    logic [DATAW-1:0] wdata_d, out_data_d;

    logic cmd_hs, in_hs, out_hs;
    assign cmd_hs = cmd_valid && cmd_ready;
    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    // Rows and C half-rows are all 8 bytes apart from their base.
    function automatic logic [ADDRW-1:0] row_addr(input logic [ADDRW-1:0] base,
                                                  input logic [CW-1:0]    idx);
        return base + (ADDRW'(idx) << 3);
    endfunction

    // State, counters and every output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wcnt_q     <= '0;
            cmd_ready  <= 1'b1;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tpu_r_w    <= 1'b0;
            tpu_addr   <= '0;
            tpu_dataIn <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wcnt_q     <= wcnt_d;
            cmd_ready  <= cmd_ready_d;
            in_ready   <= in_ready_d;
            out_valid  <= out_valid_d;
            out_data   <= out_data_d;
            busy       <= busy_d;
            done       <= done_d;
            tpu_r_w    <= r_w_d;
            tpu_addr   <= addr_d;
            tpu_dataIn <= wdata_d;
        end
    end

    // Next state and counters; counters are compared against their end value, then cleared.
    always_comb begin : next_state_logic
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_hs) begin
                    cnt_d   = '0;
                    wcnt_d  = '0;
                    state_d = cmd_accum ? S_LOAD_A : S_CLR_C;
                end
            end
            S_CLR_C: begin
                if (cnt_q == LAST_HALF) begin
                    cnt_d   = '0;
                    state_d = S_LOAD_A;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LOAD_A, S_LOAD_B: begin
                if (in_hs) begin
                    if (cnt_q == LAST_ROW) begin
                        cnt_d   = '0;
                        state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_START;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_START: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // First WAIT cycle carries the registered start access; WAIT_CYC idle cycles follow.
                if (wcnt_q == LAST_WAIT) begin
                    wcnt_d  = '0;
                    cnt_d   = '0;
                    state_d = S_READ_C;
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            S_READ_C: begin
                if (out_hs) begin
                    if (cnt_q == LAST_HALF) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; the bus defaults to idle (read of 0x0000).
    always_comb begin : output_logic
        r_w_d       = 1'b0;
        addr_d      = '0;
        wdata_d     = '0;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        in_ready_d  = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
        done_d      = (state_d == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (cmd_hs && !cmd_accum) begin
                    r_w_d  = 1'b1;
                    addr_d = row_addr(C_BASE, CW'(0));
                end
            end
            S_CLR_C: begin
                if (state_d == S_CLR_C) begin
                    r_w_d  = 1'b1;
                    addr_d = row_addr(C_BASE, cnt_d);
                end
            end
            S_LOAD_A, S_LOAD_B: begin
                if (in_hs) begin
                    r_w_d   = 1'b1;
                    addr_d  = row_addr((state_q == S_LOAD_A) ? A_BASE : B_BASE, cnt_q);
                    wdata_d = in_data;
                end
            end
            S_START: begin
                r_w_d  = 1'b1;
                addr_d = START_ADDR;
            end
            S_WAIT: begin
                if (state_d == S_READ_C) begin
                    addr_d = row_addr(C_BASE, CW'(0));
                end
            end
            S_READ_C: begin
                // Address is on the bus one cycle, data is captured, then held until accepted.
                if (!out_valid) begin
                    addr_d      = row_addr(C_BASE, cnt_q);
                    out_valid_d = 1'b1;
                    out_data_d  = tpu_dataOut;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (state_d == S_READ_C) begin
                        addr_d = row_addr(C_BASE, cnt_d);
                    end
                end else begin
                    addr_d = row_addr(C_BASE, cnt_q);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tpu_job_seq.sv
// tb_tpu_job_seq: directed bench for tpu_job_seq with a behavioural tpuv1 memory model.
module tb_tpu_job_seq;

    localparam int unsigned DIM   = 8;
    localparam int unsigned ADDRW = 16;
    localparam int unsigned DATAW = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid, cmd_ready, cmd_accum;
    logic             in_valid, in_ready;
    logic [DATAW-1:0] in_data;
    logic             out_valid, out_ready;
    logic [DATAW-1:0] out_data;
    logic             busy, done;
    logic             tpu_r_w;
    logic [ADDRW-1:0] tpu_addr;
    logic [DATAW-1:0] tpu_dataIn, tpu_dataOut;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tpu_job_seq #(.DIM(DIM), .ADDRW(ADDRW), .DATAW(DATAW), .WAIT_CYC(3 * DIM)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_accum(cmd_accum),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done),
        .tpu_r_w(tpu_r_w), .tpu_addr(tpu_addr), .tpu_dataIn(tpu_dataIn),
        .tpu_dataOut(tpu_dataOut)
    );

    // Behavioural TPU: A/B/C memories, C += A*B when the start address is seen.
    logic [63:0] a_mem [8];
    logic [63:0] b_mem [8];
    logic [63:0] c_mem [16];
    logic [63:0] nc    [16];
    logic [15:0] acc;

    assign tpu_dataOut = (tpu_addr >= 16'h300 && tpu_addr < 16'h380) ? c_mem[tpu_addr[6:3]] : 64'h0;

    always @(posedge clk) begin
        if (tpu_r_w && tpu_addr >= 16'h100 && tpu_addr < 16'h140) a_mem[tpu_addr[5:3]] <= tpu_dataIn;
        if (tpu_r_w && tpu_addr >= 16'h200 && tpu_addr < 16'h240) b_mem[tpu_addr[5:3]] <= tpu_dataIn;
        if (tpu_r_w && tpu_addr >= 16'h300 && tpu_addr < 16'h380) c_mem[tpu_addr[6:3]] <= tpu_dataIn;
        if (tpu_addr == 16'h400) begin
            for (int h = 0; h < 16; h++) nc[h] = c_mem[h];
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    acc = nc[2*r + c/4][16*(c%4) +: 16];
                    for (int k = 0; k < 8; k++)
                        acc = acc + 16'($signed(a_mem[r][8*k +: 8]) * $signed(b_mem[k][8*c +: 8]));
                    nc[2*r + c/4][16*(c%4) +: 16] = acc;
                end
            end
            for (int h = 0; h < 16; h++) c_mem[h] <= nc[h];
        end
    end

    // Stimulus rows, also used by the bus monitor to check write data.
    logic [63:0] a_rows [8];
    logic [63:0] b_rows [8];

    // Bus monitor: per-job counters restart on each command handshake.
    int clr_n, a_n, b_n, start_n, gap_n, idle_run, done_n, in_n;
    int order_err, data_err, bad_clr, bad_bus;
    int hs_total = 0, ready_viol = 0;
    bit read_seen;
    bit in_a, in_b, in_c, legal;

    always @(negedge clk) begin
        if (!rst) begin
            in_a = tpu_addr >= 16'h100 && tpu_addr < 16'h140;
            in_b = tpu_addr >= 16'h200 && tpu_addr < 16'h240;
            in_c = tpu_addr >= 16'h300 && tpu_addr < 16'h380;
            if (cmd_ready == busy) ready_viol++;
            if (cmd_valid && cmd_ready) begin
                hs_total++;
                clr_n = 0; a_n = 0; b_n = 0; start_n = 0; gap_n = -1; idle_run = 0;
                done_n = 0; in_n = 0; order_err = 0; data_err = 0; bad_clr = 0; bad_bus = 0;
                read_seen = 1'b0;
            end
            if (!busy || done)  legal = !tpu_r_w && tpu_addr == 16'h0;
            else if (tpu_r_w)   legal = in_a || in_b || in_c || tpu_addr == 16'h400;
            else                legal = tpu_addr == 16'h0 || in_c;
            if (!legal) bad_bus++;
            if (tpu_r_w && in_c) begin
                if (tpu_addr != 16'h300 + 16'(8 * clr_n)) order_err++;
                if (tpu_dataIn != 64'h0) bad_clr++;
                clr_n++;
            end
            if (tpu_r_w && in_a) begin
                if (tpu_addr != 16'h100 + 16'(8 * a_n)) order_err++;
                if (a_n < 8 && tpu_dataIn != a_rows[a_n]) data_err++;
                a_n++;
            end
            if (tpu_r_w && in_b) begin
                if (tpu_addr != 16'h200 + 16'(8 * b_n)) order_err++;
                if (b_n < 8 && tpu_dataIn != b_rows[b_n]) data_err++;
                b_n++;
            end
            if (tpu_addr == 16'h400) begin
                start_n++;
                idle_run = 0;
            end else if (start_n > 0 && !read_seen) begin
                if (!tpu_r_w && tpu_addr == 16'h0) idle_run++;
                else if (!tpu_r_w && tpu_addr == 16'h300) begin
                    read_seen = 1'b1;
                    gap_n = idle_run;
                end
            end
            if (done) done_n++;
            if (in_valid && in_ready) in_n++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic start_job(input logic accum);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_accum = accum;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Offers n beats (A rows then B rows); gaps drops in_valid for one cycle after each beat.
    task automatic feed(input int n, input bit gaps);
        int guard;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            in_data  = (i < 8) ? a_rows[i] : b_rows[i-8];
            in_valid = 1'b1;
            guard = 0;
            forever begin
                @(negedge clk);
                guard++;
                if (in_ready || guard >= 200) break;
            end
            if (guard >= 200) begin
                check("feed_timeout", 64'(guard), 64'(0));
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (gaps) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    // Consumes 16 beats; stalls beat stall_beat for 5 cycles. ramp: beat j carries j/2+1.
    task automatic drain(input int stall_beat, input logic [63:0] exp_const, input bit ramp);
        int beats, guard;
        bit acc_prev;
        logic [63:0] held, exp;
        logic [15:0] v;
        beats = 0; guard = 0; acc_prev = 1'b0;
        out_ready = 1'b1;
        while (beats < 16 && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (acc_prev) begin
                check("valid_after_accept", 64'(out_valid), 64'(0));
                acc_prev = 1'b0;
            end else if (out_valid) begin
                if (beats == stall_beat) begin
                    held = out_data;
                    out_ready = 1'b0;
                    repeat (5) begin
                        @(negedge clk);
                        check("stall_addr", 64'(tpu_addr), 64'(16'h300 + 16'(8 * stall_beat)));
                        check("stall_data", out_data, held);
                        check("stall_valid", 64'(out_valid), 64'(1));
                    end
                    out_ready = 1'b1;
                end
                v   = 16'(beats / 2 + 1);
                exp = ramp ? {v, v, v, v} : exp_const;
                check("out_beat", out_data, exp);
                beats++;
                acc_prev = 1'b1;
            end
        end
        check("beat_count", 64'(beats), 64'(16));
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (busy && guard < 200);
        check("job_end_idle", 64'(busy), 64'(0));
        repeat (5) @(negedge clk);
    endtask

    task automatic job_checks(input int exp_clr);
        check("clr_writes",  64'(clr_n),     64'(exp_clr));
        check("a_writes",    64'(a_n),       64'(8));
        check("b_writes",    64'(b_n),       64'(8));
        check("start_count", 64'(start_n),   64'(1));
        check("wait_gap",    64'(gap_n),     64'(24));
        check("done_pulses", 64'(done_n),    64'(1));
        check("addr_order",  64'(order_err), 64'(0));
        check("write_data",  64'(data_err),  64'(0));
        check("clr_data",    64'(bad_clr),   64'(0));
        check("bus_idle",    64'(bad_bus),   64'(0));
        check("in_beats",    64'(in_n),      64'(16));
    endtask

    initial begin
        int hs0, guard;
        rst = 1'b0; cmd_valid = 1'b0; cmd_accum = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            a_rows[r] = 64'h1 << (8 * r);
            b_rows[r] = 64'h0202_0202_0202_0202;
        end

        // Reset values.
        #2 rst = 1'b1;
        #1;
        check("rst_cmd_ready", 64'(cmd_ready),  64'(1));
        check("rst_in_ready",  64'(in_ready),   64'(0));
        check("rst_out_valid", 64'(out_valid),  64'(0));
        check("rst_out_data",  out_data,        64'h0);
        check("rst_busy",      64'(busy),       64'(0));
        check("rst_done",      64'(done),       64'(0));
        check("rst_r_w",       64'(tpu_r_w),    64'(0));
        check("rst_addr",      64'(tpu_addr),   64'h0);
        check("rst_dataIn",    tpu_dataIn,      64'h0);
        @(negedge clk) rst = 1'b0;

        // Reset in the middle of LOAD_A after three beats.
        start_job(1'b0);
        feed(3, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy",      64'(busy),      64'(0));
        check("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("midrst_addr",      64'(tpu_addr),  64'h0);
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready",  64'(in_ready),  64'(0));
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("postrst_busy", 64'(busy), 64'(0));

        // Fresh job, accum=0, identity A, B all 2; extra input beats offered afterwards.
        start_job(1'b0);
        feed(16, 1'b0);
        in_valid = 1'b1;
        in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        drain(-1, 64'h0002_0002_0002_0002, 1'b0);
        in_valid = 1'b0;
        wait_idle();
        job_checks(16);

        // Back-to-back accumulate job with the same operands.
        start_job(1'b1);
        feed(16, 1'b0);
        drain(-1, 64'h0004_0004_0004_0004, 1'b0);
        wait_idle();
        job_checks(0);

        // Ramp B rows, output stall on beat 3.
        for (int r = 0; r < 8; r++) b_rows[r] = {8{8'(r + 1)}};
        start_job(1'b0);
        feed(16, 1'b0);
        drain(3, 64'h0, 1'b1);
        wait_idle();
        job_checks(16);

        // in_valid toggled every other cycle during the loads.
        for (int r = 0; r < 8; r++) b_rows[r] = 64'h0202_0202_0202_0202;
        start_job(1'b0);
        feed(16, 1'b1);
        drain(-1, 64'h0002_0002_0002_0002, 1'b0);
        wait_idle();
        job_checks(16);

        // cmd_valid held high across a whole job: the next job starts right after IDLE.
        hs0 = hs_total;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_accum = 1'b0;
        @(posedge clk); #1;
        feed(16, 1'b0);
        drain(-1, 64'h0002_0002_0002_0002, 1'b0);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!done && guard < 50);
        check("held_done_seen", 64'(done), 64'(1));
        @(negedge clk);
        check("held_idle_busy",      64'(busy),      64'(0));
        check("held_idle_cmd_ready", 64'(cmd_ready), 64'(1));
        @(negedge clk);
        check("held_restart_busy",      64'(busy),      64'(1));
        check("held_restart_cmd_ready", 64'(cmd_ready), 64'(0));
        cmd_valid = 1'b0;
        feed(16, 1'b0);
        drain(-1, 64'h0002_0002_0002_0002, 1'b0);
        wait_idle();
        job_checks(16);
        check("held_job_count", 64'(hs_total - hs0), 64'(2));
        check("cmd_ready_vs_busy", 64'(ready_viol), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
